// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_share_arbiter.
// The master side issues requests and accepts responses; the arbiter is the slave.
interface alu_share_arbiter_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_op;

    logic             resp0_valid;
    logic             resp0_ready;
    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_err;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output resp0_ready, resp1_ready,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_data, resp_err, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  resp0_ready, resp1_ready,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_data, resp_err, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One transaction in flight: IDLE grant -> EXEC (1 cycle) -> RESP until accepted.
module alu_share_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter bit          RR_INIT = 1'b0
) (
    input logic                clk,
    input logic                rst,
    alu_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {Idle, Exec, Resp} arbState;

    arbState          state;
    logic             prio;
    logic             owner;
    logic [WIDTH-1:0] latA;
    logic [WIDTH-1:0] latB;
    logic [3:0]       latOp;
    logic [WIDTH-1:0] result;
    logic             errFlag;
    logic             resp0Valid;
    logic             resp1Valid;
    logic             busyFlag;

    logic             grant0;
    logic             grant1;
    logic             opErr;
    logic [WIDTH-1:0] aluSum;
    logic [WIDTH-1:0] aluOut;
    logic             ownerAccepts;

    // A lone valid wins outright; prio only breaks ties.
    assign grant0 = bus.req0_valid && (!bus.req1_valid || (prio == 1'b0));
    assign grant1 = bus.req1_valid && (!bus.req0_valid || (prio == 1'b1));

    // Gated by rst so ready drops the instant reset asserts.
    assign bus.req0_ready = !rst && (state == Idle) && grant0;
    assign bus.req1_ready = !rst && (state == Idle) && grant1;

    assign ownerAccepts = owner ? bus.resp1_ready : bus.resp0_ready;

    // Shared ALU, fed only from latched operands.
    assign aluSum = latA + latB;
    assign opErr  = latOp[3];

    always_comb begin
        aluOut = '0;
        case (latOp)
            4'd0:    aluOut = aluSum;
            4'd1:    aluOut = latB;
            4'd2:    aluOut = {aluSum[WIDTH-1:1], 1'b0};
            4'd3:    aluOut = latA - latB;
            4'd4:    aluOut = {{(WIDTH-1){1'b0}}, (latA < latB)};
            4'd5:    aluOut = {{(WIDTH-1){1'b0}}, ($signed(latA) < $signed(latB))};
            4'd6:    aluOut = latA ^ latB;
            4'd7:    aluOut = $signed(latA) >>> latB[4:0];
            default: aluOut = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= Idle;
            prio       <= RR_INIT;
            owner      <= 1'b0;
            latA       <= '0;
            latB       <= '0;
            latOp      <= '0;
            result     <= '0;
            errFlag    <= 1'b0;
            resp0Valid <= 1'b0;
            resp1Valid <= 1'b0;
            busyFlag   <= 1'b0;
        end else begin
            case (state)
                Idle: begin
                    if (grant0 || grant1) begin
                        latA     <= grant1 ? bus.req1_a  : bus.req0_a;
                        latB     <= grant1 ? bus.req1_b  : bus.req0_b;
                        latOp    <= grant1 ? bus.req1_op : bus.req0_op;
                        owner    <= grant1;
                        // Priority passes to the other side on every grant.
                        prio     <= !grant1;
                        busyFlag <= 1'b1;
                        state    <= Exec;
                    end
                end
                Exec: begin
                    result     <= opErr ? '0 : aluOut;
                    errFlag    <= opErr;
                    resp0Valid <= !owner;
                    resp1Valid <= owner;
                    state      <= Resp;
                end
                Resp: begin
                    if (ownerAccepts) begin
                        resp0Valid <= 1'b0;
                        resp1Valid <= 1'b0;
                        busyFlag   <= 1'b0;
                        state      <= Idle;
                    end
                end
                default: begin
                    state <= Idle;
                end
            endcase
        end
    end

    assign bus.resp0_valid = resp0Valid;
    assign bus.resp1_valid = resp1Valid;
    assign bus.resp_data   = result;
    assign bus.resp_err    = errFlag;
    assign bus.busy        = busyFlag;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one instance of the team's combinational ALU between two requesters: req0 is the EXU and req1 is the LSU/CSR address path.
- Each requester issues a valid/ready request carrying two operands and a 4-bit ALU op, and receives a valid/ready response carrying the result.
- One transaction is outstanding at a time. The ALU is instantiated inside this block, and its inputs are driven only from latched operands.

Parameters:
- WIDTH, 32, operand and result width.
- RR_INIT, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 request valid.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_op  in  4  requester 0 ALU op.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as the req0 ports, for requester 1.
- resp0_valid  out  1  response valid to requester 0.
- resp0_ready  in  1  requester 0 accepts the response.
- resp1_valid  out  1  response valid to requester 1.
- resp1_ready  in  1  requester 1 accepts the response.
- resp_data  out  WIDTH  result, shared by both response channels.
- resp_err  out  1  op was unsupported; qualified by resp0_valid or resp1_valid.
- busy  out  1  a transaction is in flight (state is not IDLE).

Behaviour:
- States:
  - IDLE: waiting for a request.
  - EXEC: ALU evaluates latched operands; result captured at end of cycle.
  - RESP: response presented until the target requester accepts it.
- Reset (async, rst=1), all outputs and registers forced immediately:
  - state=IDLE, prio=RR_INIT.
  - req*_ready=0, resp*_valid=0, resp_data=0, resp_err=0, busy=0.
  - Latched operands, op and owner register = 0.
- IDLE:
  - req*_ready is combinational and asserted only in IDLE, for the granted requester only.
  - If exactly one reqN_valid=1, that requester is granted.
  - If both are valid, the requester equal to prio is granted.
  - On grant (valid&&ready), latch a, b, op and owner=N; go to EXEC.
  - prio is set to the other requester (~N) on every grant, including an uncontended one.
- EXEC (exactly 1 cycle):
  - result register <= ALU output, with the ALU driven by the latched a, b, op.
  - resp_err register <= (op > 4'b0111).
  - If err, result register <= 0.
  - Go to RESP.
- RESP:
  - resp_owner_valid=1, the other resp_valid=0; resp_data and resp_err are driven from registers.
  - resp_data and resp_err stay stable until the handshake completes.
  - On resp_owner_ready=1: go to IDLE at the next edge. resp_valid drops that edge.
  - The next request cannot be granted before the following cycle; there is no bypass.
- Latency and throughput:
  - Request accept at edge N → resp_valid high in cycle N+2.
  - Best-case throughput is 1 transaction per 3 cycles.
- ALU op semantics, applied at WIDTH:
  - 0 add.
  - 1 pass B.
  - 2 (A+B) with bit0 cleared.
  - 3 A−B, wrapping modulo 2^WIDTH.
  - 4 unsigned set-less-than → 0 or 1.
  - 5 signed set-less-than → 0 or 1.
  - 6 xor.
  - 7 arithmetic right shift of A by B[4:0].
  - 8–15 unsupported: resp_err=1, resp_data=0.
- Request changes while not granted: a requester's inputs may change freely while reqN_ready=0. Only values present at the handshake edge are used.
- Withdrawal: if reqN_valid drops before grant, nothing is latched for it, and prio is unchanged.
- Back-pressure: a RESP stall of any length holds the state. The other requester stays un-ready throughout, so no starvation accounting is needed beyond prio.
- Reset mid-transaction: the in-flight result is discarded, with no response issued. After rst falls, the block starts in IDLE with prio=RR_INIT.
- resp_data while not in RESP: holds its last value. Its value outside RESP is not checked.

Test Plan:
- Single add, uncontended:
  - Stimulus: req0 a=5, b=7, op=0 accepted at edge 0; resp0_ready=1.
  - Response: resp0_valid=1 in cycle 2 with resp_data=12 and resp_err=0; busy is high in cycles 1–2.
- Contention and round-robin, RR_INIT=0, both requesters valid continuously:
  - req0 uses op=3 with a=3, b=5; req1 uses op=6 with a=0xF0F0, b=0x0FF0.
  - Grant order: req0, req1, req0.
  - Required results: req0 gets 0xFFFFFFFE; req1 gets 0x0000FF00.
  - Only one req*_ready is high in any cycle.
- Back-pressure:
  - Stimulus: req1 op=7, a=0x80000000, b=0x24; resp1_ready held 0 for 5 cycles.
  - Response: resp1_valid is held with resp_data=0xF8000000, stable the whole time.
  - req0_valid=1 meanwhile sees req0_ready=0 throughout; req0 is granted the cycle after the resp1 handshake.
- Signed vs unsigned compare:
  - a=0xFFFFFFFF, b=1, op=4 → 0.
  - Same operands, op=5 → 1.
  - a=3, b=4, op=2 → 6.
- Unsupported op:
  - Stimulus: op=4'hA.
  - Response: resp_err=1, resp_data=0. The next request with op=1, b=0x1234 returns 0x1234 with resp_err=0.
- Async reset during EXEC:
  - Stimulus: assert rst between clock edges while in EXEC.
  - Response: busy and all valid/ready outputs drop to 0 immediately, with no clock edge needed.
  - After release, a contended request is granted to RR_INIT.
